// File: rtl/matrix_rx_pkg.sv
// Shared constants, pixel-word layout and FSM encoding for the LED-matrix receiver.
package matrix_rx_pkg;

  localparam int COLS_DEF     = 32;
  localparam int ROW_BITS_DEF = 4;

  // One shifted pixel word holds both halves: {lower r,g,b, upper r,g,b}
  localparam int RGB_W  = 3;
  localparam int PIX_W  = 2 * RGB_W;
  localparam int UP_LSB = 0;
  localparam int LO_LSB = RGB_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  function automatic logic [PIX_W-1:0] pack_pixel(input logic [1:0] r,
                                                  input logic [1:0] g,
                                                  input logic [1:0] b);
    return {r[1], g[1], b[1], r[0], g[0], b[0]};
  endfunction

endpackage

// File: rtl/matrix_rx_if.sv
// Pixel-write stream from the receiver to a framebuffer or checker.
interface matrix_rx_if
  import matrix_rx_pkg::*;
#(
  parameter int COLS     = COLS_DEF,
  parameter int ROW_BITS = ROW_BITS_DEF
);
  logic                      pix_valid;
  logic                      pix_ready;
  logic [$clog2(COLS)-1:0]   pix_x;
  logic [ROW_BITS:0]         pix_y;
  logic [RGB_W-1:0]          pix_rgb;

  modport master (output pix_valid, pix_x, pix_y, pix_rgb, input pix_ready);
  modport slave  (input pix_valid, pix_x, pix_y, pix_rgb, output pix_ready);
endinterface

// File: rtl/matrix_rx_sync_edge.sv
// Two-flop synchronizer for one asynchronous control line plus a rising-edge pulse.
module matrix_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_s,
  output logic o_rise
);
  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  // NOTE: non-blocking assignments make every flop sample the pre-edge value,
  // so the chain really is three stages deep regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_d;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_s    = r_sync;
  assign o_rise = r_sync & ~r_sync_d;
endmodule

// File: rtl/matrix_rx.sv
// Captures one dual-row panel line per latch and replays it as (x,y,rgb) pixel beats,
// upper half then lower half for each column.
module matrix_rx
  import matrix_rx_pkg::*;
#(
  parameter int COLS     = COLS_DEF,
  parameter int ROW_BITS = ROW_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          i_mat_r,
  input  logic [1:0]          i_mat_g,
  input  logic [1:0]          i_mat_b,
  input  logic [ROW_BITS-1:0] i_mat_row,
  input  logic                i_mat_clk,
  input  logic                i_mat_lat,
  input  logic                i_mat_oe,
  input  logic                i_clr_status,
  output logic                o_frame_start,
  output logic                o_ovf,
  output logic                o_len_err,
  matrix_rx_if.master         pix
);
  localparam int XW = $clog2(COLS);
  localparam int CW = $clog2(COLS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(COLS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(COLS + 1);
  localparam logic [XW-1:0] X_LAST   = XW'(COLS - 1);

  logic w_mclk_s, w_clk_rise;
  logic w_mlat_s, w_lat_rise;
  logic w_oe_s,   w_oe_rise;
  logic w_unused;

  matrix_sync_edge u_sync_clk (.clk(clk), .rst(rst), .i_d(i_mat_clk), .o_s(w_mclk_s), .o_rise(w_clk_rise));
  matrix_sync_edge u_sync_lat (.clk(clk), .rst(rst), .i_d(i_mat_lat), .o_s(w_mlat_s), .o_rise(w_lat_rise));
  matrix_sync_edge u_sync_oe  (.clk(clk), .rst(rst), .i_d(i_mat_oe),  .o_s(w_oe_s),   .o_rise(w_oe_rise));

  // Output enable is synchronized for completeness but has no effect on capture.
  assign w_unused = &{1'b0, w_mclk_s, w_mlat_s, w_oe_s, w_oe_rise};

  // Data buses use the same two-flop depth so they line up with the edge pulses.
  logic [PIX_W-1:0]    r_dat_meta, r_dat_s;
  logic [ROW_BITS-1:0] r_row_meta, r_row_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dat_meta <= '0;
      r_dat_s    <= '0;
      r_row_meta <= '0;
      r_row_s    <= '0;
    end else begin
      r_dat_meta <= pack_pixel(i_mat_r, i_mat_g, i_mat_b);
      r_dat_s    <= r_dat_meta;
      r_row_meta <= i_mat_row;
      r_row_s    <= r_row_meta;
    end
  end

  logic [PIX_W-1:0] r_shift      [COLS];
  logic [PIX_W-1:0] w_shift_next [COLS];
  logic [PIX_W-1:0] r_hold       [COLS];
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;

  // Index x of the shift register ends up holding column x after a full line.
  // NOTE: the default copy before the conditional keeps this block free of latches.
  always_comb begin
    w_shift_next = r_shift;
    if (w_clk_rise) begin
      w_shift_next[0] = r_dat_s;
      for (int i = 1; i < COLS; i++) w_shift_next[i] = r_shift[i-1];
    end
  end

  assign w_cnt_next = (w_clk_rise && r_cnt != CNT_SAT) ? r_cnt + 1'b1 : r_cnt;

  state_t            r_state;
  logic              r_valid;
  logic [XW-1:0]     r_x;
  logic              r_half;
  logic [ROW_BITS-1:0] r_row;
  logic              r_frame_start;
  logic              r_ovf;
  logic              r_len_err;
  logic              w_accept;
  logic              w_hs;

  assign w_accept = w_lat_rise && (r_state == ST_IDLE);
  assign w_hs     = r_valid & pix.pix_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < COLS; i++) r_shift[i] <= '0;
      r_cnt <= '0;
    end else begin
      r_shift <= w_shift_next;
      r_cnt   <= w_lat_rise ? '0 : w_cnt_next;
    end
  end

  // NOTE: the hold buffer is cleared on reset so a line emitted after reset never
  // carries pixels from before it; a reset-free RAM would need a write-before-read guard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < COLS; i++) r_hold[i] <= '0;
    end else if (w_accept) begin
      r_hold <= w_shift_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_valid       <= 1'b0;
      r_x           <= '0;
      r_half        <= 1'b0;
      r_row         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_lat_rise) begin
            r_state       <= ST_EMIT;
            r_valid       <= 1'b1;
            r_x           <= '0;
            r_half        <= 1'b0;
            r_row         <= r_row_s;
            r_frame_start <= (r_row_s == '0);
          end
        end
        ST_EMIT: begin
          if (w_hs) begin
            if (!r_half) begin
              r_half <= 1'b1;
            end else begin
              r_half <= 1'b0;
              if (r_x == X_LAST) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
              end else begin
                r_x <= r_x + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf     <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      if (w_lat_rise && w_cnt_next != CNT_FULL) r_len_err <= 1'b1;
      else if (i_clr_status)                    r_len_err <= 1'b0;
      if (w_lat_rise && r_state != ST_IDLE)     r_ovf     <= 1'b1;
      else if (i_clr_status)                    r_ovf     <= 1'b0;
    end
  end

  assign pix.pix_valid = r_valid;
  assign pix.pix_x     = r_x;
  assign pix.pix_y     = {r_half, r_row};
  assign pix.pix_rgb   = r_half ? r_hold[r_x][LO_LSB +: RGB_W] : r_hold[r_x][UP_LSB +: RGB_W];

  assign o_frame_start = r_frame_start;
  assign o_ovf         = r_ovf;
  assign o_len_err     = r_len_err;
endmodule

// File: tb/tb_matrix_rx.sv
// Directed bench for matrix_rx: table of single-pixel lines plus hand-written
// sequences for short lines, overflow, random back-pressure and mid-line reset.
module tb_matrix_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] i_mat_r = '0, i_mat_g = '0, i_mat_b = '0;
  logic [3:0] i_mat_row = '0;
  logic       i_mat_clk = 1'b0, i_mat_lat = 1'b0, i_mat_oe = 1'b0;
  logic       i_clr_status = 1'b0;
  logic       o_frame_start, o_ovf, o_len_err;

  matrix_rx_if #(.COLS(32), .ROW_BITS(4)) pix_if ();

  matrix_rx #(.COLS(32), .ROW_BITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_mat_r      (i_mat_r),
    .i_mat_g      (i_mat_g),
    .i_mat_b      (i_mat_b),
    .i_mat_row    (i_mat_row),
    .i_mat_clk    (i_mat_clk),
    .i_mat_lat    (i_mat_lat),
    .i_mat_oe     (i_mat_oe),
    .i_clr_status (i_clr_status),
    .o_frame_start(o_frame_start),
    .o_ovf        (o_ovf),
    .o_len_err    (o_len_err),
    .pix          (pix_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [2:0] rgb;
  } beat_t;

  typedef struct {
    int         k;      // shift index of the one non-zero pixel
    logic [5:0] v;      // {lo r,g,b, up r,g,b}
    logic [3:0] row;
    int         ex;     // expected column
    int         yu;
    int         yl;
    logic [2:0] rgbu;
    logic [2:0] rgbl;
    int         fs;     // expected frame_start pulses
  } vec_t;

  beat_t beats[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    fs_cnt   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Handshake capture, frame_start counting and stall stability, sampled mid-cycle.
  initial begin : monitor
    logic  stall_prev;
    beat_t held;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && pix_if.pix_valid)
          check("stall_stable", int'({pix_if.pix_x, pix_if.pix_y, pix_if.pix_rgb}), int'(held));
        if (o_frame_start) fs_cnt++;
        if (pix_if.pix_valid && pix_if.pix_ready)
          beats.push_back({pix_if.pix_x, pix_if.pix_y, pix_if.pix_rgb});
        stall_prev = pix_if.pix_valid && !pix_if.pix_ready;
        held = {pix_if.pix_x, pix_if.pix_y, pix_if.pix_rgb};
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2;
    pix_if.pix_ready = v;
  endtask

  task automatic shift_px(input logic [5:0] v);
    @(negedge clk);
    i_mat_r   = {v[5], v[2]};
    i_mat_g   = {v[4], v[1]};
    i_mat_b   = {v[3], v[0]};
    i_mat_clk = 1'b0;
    repeat (3) @(negedge clk);
    i_mat_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic latch(input logic [3:0] row);
    @(negedge clk);
    i_mat_row = row;
    repeat (3) @(negedge clk);
    i_mat_lat = 1'b1;
    repeat (4) @(negedge clk);
    i_mat_lat = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_line(input int k_sel, input logic [5:0] v, input int nbits, input logic [3:0] row);
    for (int i = 0; i < nbits; i++) shift_px((i == k_sel) ? v : 6'd0);
    latch(row);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    i_clr_status = 1'b1;
    @(negedge clk);
    i_clr_status = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (beats.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    check("beat_count", beats.size(), n);
    check("valid_idle", int'(pix_if.pix_valid), 0);
  endtask

  task automatic check_line(input vec_t vc, input int base);
    int    errs;
    int    bx;
    int    half;
    int    ey;
    int    erg;
    beat_t b;
    errs = 0;
    if (beats.size() >= base + 64) begin
      for (int i = 0; i < 64; i++) begin
        bx   = i / 2;
        half = i % 2;
        ey   = half ? vc.yl : vc.yu;
        erg  = (bx == vc.ex) ? int'(half ? vc.rgbl : vc.rgbu) : 0;
        b    = beats[base + i];
        if (int'(b.x) != bx || int'(b.y) != ey || int'(b.rgb) != erg) errs++;
      end
      check("line_beats", errs, 0);
      check("target_upper_rgb", int'(beats[base + 2*vc.ex].rgb), int'(vc.rgbu));
      check("target_lower_y",   int'(beats[base + 2*vc.ex + 1].y), vc.yl);
      check("target_lower_rgb", int'(beats[base + 2*vc.ex + 1].rgb), int'(vc.rgbl));
    end
  endtask

  initial begin : main
    vec_t       vecs[5];
    vec_t       vt;
    int         base;
    int         fs0;
    int         errs;
    int         t;
    logic [5:0] kv;
    int         bx;
    int         half;

    vecs[0] = '{k:0,  v:6'b000_100, row:4'd5,  ex:31, yu:5,  yl:21, rgbu:3'b100, rgbl:3'b000, fs:0};
    vecs[1] = '{k:31, v:6'b001_000, row:4'd15, ex:0,  yu:15, yl:31, rgbu:3'b000, rgbl:3'b001, fs:0};
    vecs[2] = '{k:10, v:6'b101_110, row:4'd0,  ex:21, yu:0,  yl:16, rgbu:3'b110, rgbl:3'b101, fs:1};
    vecs[3] = '{k:5,  v:6'b010_000, row:4'd9,  ex:26, yu:9,  yl:25, rgbu:3'b000, rgbl:3'b010, fs:0};
    vecs[4] = '{k:16, v:6'b111_111, row:4'd12, ex:15, yu:12, yl:28, rgbu:3'b111, rgbl:3'b111, fs:0};

    pix_if.pix_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_valid",       int'(pix_if.pix_valid), 0);
    check("rst_frame_start", int'(o_frame_start), 0);
    check("rst_ovf",         int'(o_ovf), 0);
    check("rst_len_err",     int'(o_len_err), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Full-length single-pixel lines
    for (int v = 0; v < 5; v++) begin
      base = beats.size();
      fs0  = fs_cnt;
      send_line(vecs[v].k, vecs[v].v, 32, vecs[v].row);
      wait_beats(base + 64);
      check_line(vecs[v], base);
      check("frame_start_pulses", fs_cnt - fs0, vecs[v].fs);
      check("len_err_clean", int'(o_len_err), 0);
      check("ovf_clean", int'(o_ovf), 0);
    end

    // Short line: 31 shifts, first pixel lands at column 30
    base = beats.size();
    send_line(0, 6'b000_010, 31, 4'd7);
    check("short_len_err", int'(o_len_err), 1);
    wait_beats(base + 64);
    if (beats.size() >= base + 64) begin
      check("short_x",   int'(beats[base + 60].x), 30);
      check("short_y",   int'(beats[base + 60].y), 7);
      check("short_rgb", int'(beats[base + 60].rgb), 3'b010);
    end
    clr_pulse();
    check("len_err_cleared", int'(o_len_err), 0);

    // Overflow: second line latched while the first is stalled
    set_ready(1'b0);
    base = beats.size();
    send_line(0, 6'b000_100, 32, 4'd1);
    check("stalled_valid", int'(pix_if.pix_valid), 1);
    send_line(3, 6'b111_111, 32, 4'd2);
    check("ovf_set", int'(o_ovf), 1);
    check("ovf_no_len_err", int'(o_len_err), 0);
    set_ready(1'b1);
    wait_beats(base + 64);
    vt = '{k:0, v:6'b000_100, row:4'd1, ex:31, yu:1, yl:17, rgbu:3'b100, rgbl:3'b000, fs:0};
    check_line(vt, base);
    check("ovf_sticky", int'(o_ovf), 1);
    clr_pulse();
    check("ovf_cleared", int'(o_ovf), 0);

    // Random back-pressure over a line where every column is distinct
    set_ready(1'b0);
    base = beats.size();
    for (int k = 0; k < 32; k++) shift_px(6'(k));
    latch(4'd3);
    t = 0;
    while (beats.size() < base + 64 && t < 4000) begin
      @(posedge clk);
      #2;
      pix_if.pix_ready = 1'($urandom_range(0, 1));
      t++;
    end
    set_ready(1'b1);
    wait_beats(base + 64);
    errs = 0;
    if (beats.size() >= base + 64) begin
      for (int i = 0; i < 64; i++) begin
        bx   = i / 2;
        half = i % 2;
        kv   = 6'(31 - bx);
        if (int'(beats[base + i].x) != bx ||
            int'(beats[base + i].y) != (half ? 19 : 3) ||
            beats[base + i].rgb != (half ? kv[5:3] : kv[2:0])) errs++;
      end
    end
    check("rand_ready_order", errs, 0);

    // Reset during a stalled emit with both status flags set
    set_ready(1'b0);
    send_line(0, 6'b000_000, 31, 4'd2);
    latch(4'd2);
    check("pre_rst_ovf", int'(o_ovf), 1);
    check("pre_rst_len_err", int'(o_len_err), 1);
    check("pre_rst_valid", int'(pix_if.pix_valid), 1);
    @(negedge clk);
    i_mat_clk = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_valid", int'(pix_if.pix_valid), 0);
    check("rst_async_ovf", int'(o_ovf), 0);
    check("rst_async_len_err", int'(o_len_err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    set_ready(1'b1);
    base = beats.size();
    vt = '{k:3, v:6'b100_001, row:4'd4, ex:28, yu:4, yl:20, rgbu:3'b001, rgbl:3'b100, fs:0};
    send_line(vt.k, vt.v, 32, vt.row);
    wait_beats(base + 64);
    check_line(vt, base);
    check("post_rst_len_err", int'(o_len_err), 0);
    check("post_rst_ovf", int'(o_ovf), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
